// File: rtl/fetch_ctrl_pkg.sv
// Shared front-end types: instruction-bus request/response, reset PC and the
// fetch sequencer's state encoding.
package fetch_ctrl_pkg;

    localparam logic [63:0] PCINIT      = 64'h0000_0000_8000_0000;
    localparam int          INSTR_BYTES = 4;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one ibus transaction at a time, a valid/ready
// output register for the fetched instruction, and redirect absorption.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PCINIT
) (
    input  logic         clk,
    input  logic         reset,
    output ibus_req_t    ireq,
    input  ibus_resp_t   iresp,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_instr,
    output logic [63:0]  out_pc,
    output logic         busy,
    output fetch_state_t dbg_state
);

    // Handshake: an instruction transfers on any edge where out_valid and
    // out_ready are both high; out_valid/out_instr/out_pc hold until then.
    fetch_state_t state, state_nx;
    logic [63:0]  fetch_pc, fetch_pc_nx;
    logic [63:0]  tgt_pc, tgt_pc_nx;
    logic         drop, drop_nx;
    logic         req_valid;
    logic         busy_q;
    logic         completion;
    logic         load;

    assign completion = ((state == ADDR) && iresp.addr_ok && iresp.data_ok) ||
                        ((state == DATA) && iresp.data_ok);
    assign load       = completion && !redirect_valid && !drop;

    assign ireq.valid = req_valid;
    assign ireq.addr  = fetch_pc;
    assign busy       = busy_q;
    assign dbg_state  = state;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        tgt_pc_nx   = tgt_pc;
        drop_nx     = drop;
        case (state)
            IDLE: begin
                if (redirect_valid)
                    fetch_pc_nx = redirect_pc;
                else if (!out_valid || out_ready)
                    state_nx = ADDR;
            end
            ADDR, DATA: begin
                if (completion) begin
                    state_nx = IDLE;
                    drop_nx  = 1'b0;
                    if (redirect_valid)
                        fetch_pc_nx = redirect_pc;
                    else if (drop)
                        fetch_pc_nx = tgt_pc;
                    else
                        fetch_pc_nx = fetch_pc + 64'(INSTR_BYTES);
                end else begin
                    // Address is held until addr_ok; a redirect is parked in tgt_pc.
                    if ((state == ADDR) && iresp.addr_ok)
                        state_nx = DATA;
                    if (redirect_valid) begin
                        tgt_pc_nx = redirect_pc;
                        drop_nx   = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            tgt_pc    <= '0;
            drop      <= 1'b0;
            req_valid <= 1'b0;
            busy_q    <= 1'b0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else begin
            state     <= state_nx;
            fetch_pc  <= fetch_pc_nx;
            tgt_pc    <= tgt_pc_nx;
            drop      <= drop_nx;
            req_valid <= (state_nx == ADDR);
            busy_q    <= (state_nx != IDLE);
            if (load) begin
                out_valid <= 1'b1;
                out_instr <= iresp.data;
                out_pc    <= fetch_pc;
            end else if (redirect_valid) begin
                out_valid <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic         clk;
    logic         reset;
    ibus_req_t    ireq;
    ibus_resp_t   iresp;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic [63:0]  out_pc;
    logic         busy;
    fetch_state_t dbg_state;

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // The bench must never present responses the bus protocol forbids.
    always @(negedge clk) begin
        if (reset && !busy && (iresp.addr_ok || iresp.data_ok)) begin
            bad++;
            $error("FAIL protocol_idle_resp: observed=1 expected=0");
        end
        if (reset && ireq.valid && iresp.data_ok && !iresp.addr_ok) begin
            bad++;
            $error("FAIL protocol_data_without_addr: observed=1 expected=0");
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_resp(input logic aok, input logic dok, input logic [31:0] d);
        iresp.addr_ok = aok;
        iresp.data_ok = dok;
        iresp.data    = d;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        set_resp(1'b0, 1'b0, 32'h0);

        // Reset held for 3 cycles
        repeat (3) tick();
        check("rst_req_valid", 64'(ireq.valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_out_pc",    out_pc, 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        reset = 1'b1;
        #1;
        check("idle_after_release", 64'(ireq.valid), 64'd0);
        tick();
        check("first_req_valid", 64'(ireq.valid), 64'd1);
        check("first_req_addr",  ireq.addr, 64'h8000_0000);
        check("first_busy",      64'(busy), 64'd1);

        // Zero-wait bus, out_ready high
        out_ready = 1'b1;
        set_resp(1'b1, 1'b1, 32'h0000_0013);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        check("zw0_out_valid", 64'(out_valid), 64'd1);
        check("zw0_out_pc",    out_pc, 64'h8000_0000);
        check("zw0_out_instr", 64'(out_instr), 64'h13);
        check("zw0_req_idle",  64'(ireq.valid), 64'd0);
        tick();
        check("zw1_req_valid", 64'(ireq.valid), 64'd1);
        check("zw1_req_addr",  ireq.addr, 64'h8000_0004);
        check("zw1_out_drained", 64'(out_valid), 64'd0);
        set_resp(1'b1, 1'b1, 32'h0010_0093);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        check("zw1_out_pc",    out_pc, 64'h8000_0004);
        check("zw1_out_instr", 64'(out_instr), 64'h0010_0093);
        tick();
        check("zw2_req_addr",  ireq.addr, 64'h8000_0008);
        check("zw2_req_valid", 64'(ireq.valid), 64'd1);

        // Split response: addr_ok at N, data_ok at N+3
        set_resp(1'b1, 1'b0, 32'h0);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        check("split_n1_req", 64'(ireq.valid), 64'd0);
        check("split_n1_state", 64'(dbg_state), 64'(DATA));
        tick();
        check("split_n2_req", 64'(ireq.valid), 64'd0);
        tick();
        check("split_n3_req", 64'(ireq.valid), 64'd0);
        check("split_n3_out_valid", 64'(out_valid), 64'd0);
        set_resp(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        check("split_out_valid", 64'(out_valid), 64'd1);
        check("split_out_pc",    out_pc, 64'h8000_0008);
        check("split_out_instr", 64'(out_instr), 64'hDEAD_BEEF);

        // Backpressure: slot full and out_ready low keeps the fetcher idle
        out_ready = 1'b0;
        tick();
        check("bp_req_idle",  64'(ireq.valid), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        tick();
        check("bp_req_idle2",  64'(ireq.valid), 64'd0);
        check("bp_instr_held", 64'(out_instr), 64'hDEAD_BEEF);
        check("bp_busy",       64'(busy), 64'd0);
        out_ready = 1'b1;
        tick();
        check("bp_release_req",  64'(ireq.valid), 64'd1);
        check("bp_release_addr", ireq.addr, 64'h8000_000C);
        check("bp_release_out",  64'(out_valid), 64'd0);

        // Redirect during ADDR while addr_ok is held low for 2 cycles
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        check("rda_addr_hold1", ireq.addr, 64'h8000_000C);
        check("rda_valid_hold1", 64'(ireq.valid), 64'd1);
        tick();
        check("rda_addr_hold2", ireq.addr, 64'h8000_000C);
        set_resp(1'b1, 1'b1, 32'h0BAD_0BAD);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        check("rda_dropped", 64'(out_valid), 64'd0);
        check("rda_idle",    64'(ireq.valid), 64'd0);
        tick();
        check("rda_new_req",  64'(ireq.valid), 64'd1);
        check("rda_new_addr", ireq.addr, 64'h8000_1000);

        // Redirect coincident with data_ok
        set_resp(1'b1, 1'b0, 32'h0);
        tick();
        set_resp(1'b0, 1'b1, 32'h1111_1111);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        check("rdc_dropped", 64'(out_valid), 64'd0);
        check("rdc_idle",    64'(busy), 64'd0);
        tick();
        check("rdc_new_addr", ireq.addr, 64'h8000_2000);
        check("rdc_new_req",  64'(ireq.valid), 64'd1);

        // Reset asserted mid-DATA; the late data_ok is ignored
        set_resp(1'b1, 1'b0, 32'h0);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        check("mid_data_state", 64'(dbg_state), 64'(DATA));
        reset = 1'b0;
        #1;
        check("mid_rst_req",   64'(ireq.valid), 64'd0);
        check("mid_rst_out",   64'(out_valid), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        set_resp(1'b0, 1'b1, 32'h2222_2222);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        check("post_rst_out", 64'(out_valid), 64'd0);
        tick();
        check("post_rst_req",  64'(ireq.valid), 64'd1);
        check("post_rst_addr", ireq.addr, 64'h8000_0000);

        // Redirect while IDLE with a full slot beats a stalled consumer; PC wraps
        set_resp(1'b1, 1'b1, 32'h0000_0033);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        check("wrap_first_out", 64'(out_valid), 64'd1);
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("idle_redir_clears_out", 64'(out_valid), 64'd0);
        check("idle_redir_no_req",     64'(ireq.valid), 64'd0);
        tick();
        out_ready = 1'b1;
        check("wrap_req_addr", ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
        set_resp(1'b1, 1'b1, 32'h0000_0077);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        check("wrap_out_pc",    out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_out_instr", 64'(out_instr), 64'h77);
        tick();
        check("wrap_next_addr", ireq.addr, 64'h0);
        check("wrap_next_req",  64'(ireq.valid), 64'd1);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer between the core front end and the instruction bus.
- Owns the fetch PC and issues one ibus request at a time.
- Tracks the addr_ok/data_ok phases, presents each fetched instruction through a valid/ready output register, and absorbs control-flow redirects mid-transaction.
- Non-pipelined: at most one bus transaction outstanding.

Parameters:
RESET_PC, PCINIT (common package), fetch address after reset
INSTR_BYTES, 4, sequential PC increment

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
ireq  out  ibus_req_t  bus request (valid, addr)
iresp  in  ibus_resp_t  bus response (addr_ok, data_ok, data[31:0])
redirect_valid  in  1  flush and refetch from redirect_pc
redirect_pc  in  64  redirect target
out_valid  out  1  instruction available
out_ready  in  1  downstream accepts instruction
out_instr  out  32  fetched instruction
out_pc  out  64  address of out_instr
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, fetch_pc=RESET_PC, tgt_pc=0, drop=0.
  - out_valid=0, out_instr=0, out_pc=0.
  - ireq.valid=0.
  - Reset asserted mid-transaction abandons the transaction immediately; the late response is ignored.
- Registers: fetch_pc (bus address), tgt_pc (pending redirect target), drop (discard in-flight response).
- ireq.addr=fetch_pc always. ireq.valid=1 only in ADDR. busy=(state!=IDLE).
- Bus rule: once ireq.valid=1, valid and addr are held stable until addr_ok.
- Completion = (ADDR & addr_ok & data_ok) | (DATA & data_ok).
- IDLE:
  - redirect_valid: fetch_pc<=redirect_pc, stay IDLE.
  - else if (!out_valid | out_ready): go to ADDR.
  - else stay IDLE.
- ADDR:
  - completion: go to IDLE.
  - addr_ok & !data_ok: go to DATA.
  - else stay ADDR (addr unchanged).
- DATA: ireq.valid=0. On completion, go to IDLE.
- Normal completion (drop=0, no redirect this cycle): out_instr<=iresp.data, out_pc<=fetch_pc, out_valid<=1, fetch_pc<=fetch_pc+INSTR_BYTES (64-bit wrap).
- Redirect in ADDR/DATA without completion: tgt_pc<=redirect_pc, drop<=1. A later redirect overwrites tgt_pc (latest wins).
- Completion with a redirect in the same cycle: discard data, fetch_pc<=redirect_pc, drop<=0.
- Completion with drop=1 and no redirect that cycle: discard data, fetch_pc<=tgt_pc, drop<=0.
- Output register:
  - Any redirect_valid clears out_valid at the next edge, even if out_ready is high (redirect wins).
  - Otherwise out_valid clears when out_valid & out_ready and no load occurs.
  - Entry to ADDR requires the slot to be free, so the slot is always free at completion.
- Latency: IDLE→ADDR takes 1 cycle. With a zero-wait bus, out_valid is set at the edge after ADDR. Peak rate is 1 instruction per 2 cycles.
- addr_ok/data_ok in IDLE, or data_ok without addr_ok in ADDR, are ignored (protocol error, assertion in bench).

Decomposition:
- common package: add fetch_state_t enum (IDLE, ADDR, DATA) and INSTR_BYTES. ibus_req_t, ibus_resp_t and PCINIT are already there.
- Single module; no sub-module is warranted.

Test Plan:
- Reset: hold reset=0 for 3 cycles → ireq.valid=0, out_valid=0. Release → IDLE for 1 cycle, then ireq.valid=1 with addr=PCINIT (0x8000_0000).
- Zero-wait bus, out_ready=1, data 0x00000013 → out_valid=1, out_pc=0x8000_0000. Next request addr=0x8000_0004 two cycles later. Steady 1 instruction per 2 cycles.
- Split response: addr_ok at cycle N, data_ok at N+3 → ireq.valid=0 during N+1..N+3. out_valid at N+4 with the correct data/pc.
- Backpressure: out_ready=0 after the first instruction → stays IDLE with no request and out_instr held. Set out_ready=1 → request addr 0x8000_0004 the next cycle.
- Redirect during ADDR while addr_ok is held low 2 cycles, redirect_pc=0x8000_1000:
  - ireq.addr stays 0x8000_0004 until addr_ok.
  - The response is discarded (out_valid stays 0).
  - The next request addr is 0x8000_1000.
- Redirect coincident with data_ok (0x8000_2000), then reset=0 asserted mid-DATA on a later fetch:
  - The coincident response is discarded and the next addr is 0x8000_2000.
  - The reset immediately forces ireq.valid=0 and out_valid=0.
  - After release, the first request addr is PCINIT.
